mod_mul: RTL and testbench

MOD_MUL -- requirements
Module: mod_mul

---
 rtl/mod_mul_pkg.sv | 11 +
 rtl/mod_shift_add_step.sv | 23 ++
 rtl/mod_mul.sv | 104 ++++++++++
 tb/tb_mod_mul.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_mul_pkg.sv
// Shared FSM encoding and sizing helper for the modular multiplier.
package mod_mul_pkg;

  typedef enum logic [1:0] {IDLE, REDUCE, MUL, DONE} state_t;

  // Counter width used to index one operand bit per cycle; never zero.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mod_shift_add_step.sv
// One double-and-add step modulo p: y = (2*x + addend) mod p,
// valid whenever x < p and addend < p, so that the sum stays below 3p.
module mod_shift_add_step #(
  parameter int               width = 128,
  parameter logic [width-1:0] p     = 37
) (
  input  logic [width+1:0] x,
  input  logic [width+1:0] addend,
  output logic [width+1:0] y
);

  localparam logic [width+1:0] P_EXT = {2'b00, p};

  logic [width+1:0] sum;
  logic [width+1:0] once;

  always_comb begin
    sum  = (x << 1) + addend;
    once = (sum >= P_EXT) ? sum - P_EXT : sum;
    y    = (once >= P_EXT) ? once - P_EXT : once;
  end

endmodule

// File: rtl/mod_mul.sv
// Free-running modular multiplier: r = (a*b) mod p, recomputed whenever a or b
// changes. b is first reduced mod p, then a is scanned MSB first by double-and-add.
module mod_mul
  import mod_mul_pkg::*;
#(
  parameter int               width = 128,
  parameter logic [width-1:0] p     = 37
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] r,
  output logic             done
);

  localparam int          CW       = cnt_width(width);
  localparam logic [CW:0] LAST_BIT = (CW+1)'(width - 1);
  localparam logic [CW:0] MUL_END  = (CW+1)'(width);

  state_t           state_q, state_d;
  logic [CW:0]      cnt_q;
  logic [width-1:0] a_q, b_q;
  logic [width+1:0] rem_q, acc_q;
  logic [CW-1:0]    bit_idx;
  logic             changed;
  logic [width+1:0] step_x, step_add, step_y;

  assign bit_idx = LAST_BIT[CW-1:0] - cnt_q[CW-1:0];
  assign changed = (a != a_q) || (b != b_q);

  // The single step unit is time-shared: it reduces b_q in REDUCE and accumulates in MUL.
  always_comb begin
    step_x   = rem_q;
    step_add = {{(width+1){1'b0}}, b_q[bit_idx]};
    if (state_q == MUL) begin
      step_x   = acc_q;
      step_add = a_q[bit_idx] ? rem_q : '0;
    end
  end

  mod_shift_add_step #(.width(width), .p(p)) u_step (
    .x      (step_x),
    .addend (step_add),
    .y      (step_y)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REDUCE;
      REDUCE:  if (cnt_q == LAST_BIT) state_d = MUL;
      MUL:     if (cnt_q == MUL_END) state_d = DONE;
      DONE:    if (changed) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MUL spends one extra cycle at MUL_END to publish the settled accumulator.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rem_q <= '0;
      acc_q <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          a_q   <= a;
          b_q   <= b;
          rem_q <= '0;
          acc_q <= '0;
          cnt_q <= '0;
        end
        REDUCE: begin
          rem_q <= step_y;
          cnt_q <= (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
        end
        MUL: begin
          if (cnt_q == MUL_END) begin
            r    <= acc_q[width-1:0];
            done <= 1'b1;
          end else begin
            acc_q <= step_y;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (changed) done <= 1'b0;
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul.sv
// Bench for mod_mul: two instances (p=37 and p=2^127-1) share operands and are
// compared every cycle against a latency-and-arithmetic model of the block.
module tb_mod_mul;

  localparam int           W   = 128;
  localparam logic [W-1:0] P0  = 37;
  localparam logic [W-1:0] P1  = {1'b0, {(W-1){1'b1}}};
  localparam int           LAT = 2*W + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b;
  logic [W-1:0] r0, r1;
  logic         done0, done1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_mul #(.width(W), .p(P0)) dut0 (
    .clk(clk), .reset(reset), .a(a), .b(b), .r(r0), .done(done0)
  );

  mod_mul #(.width(W), .p(P1)) dut1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .r(r1), .done(done1)
  );

  function automatic logic [W-1:0] ref_mod(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(prod % {{W{1'b0}}, m});
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: an idle block latches operands, answers LAT edges later, then holds
  // until the operands on the pins differ from the latched pair.
  logic [W-1:0] pm [2] = '{P0, P1};
  logic [W-1:0] m_r [2];
  logic [W-1:0] m_a [2];
  logic [W-1:0] m_b [2];
  logic         m_done [2];
  logic         m_busy [2];
  int           m_left [2];

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_r[k]    <= '0;
        m_a[k]    <= '0;
        m_b[k]    <= '0;
        m_done[k] <= 1'b0;
        m_busy[k] <= 1'b0;
        m_left[k] <= 0;
      end else if (m_busy[k]) begin
        if (m_left[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_done[k] <= 1'b1;
          m_r[k]    <= ref_mod(m_a[k], m_b[k], pm[k]);
        end
        m_left[k] <= m_left[k] - 1;
      end else if (m_done[k]) begin
        if (a != m_a[k] || b != m_b[k]) m_done[k] <= 1'b0;
      end else begin
        m_a[k]    <= a;
        m_b[k]    <= b;
        m_busy[k] <= 1'b1;
        m_left[k] <= LAT;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("done_p37", W'(done0), W'(m_done[0]));
    checkOutput("r_p37", r0, m_r[0]);
    checkOutput("r_lt_p37", W'(r0 < P0), W'(1'b1));
    checkOutput("done_pm127", W'(done1), W'(m_done[1]));
    checkOutput("r_pm127", r1, m_r[1]);
    checkOutput("r_lt_pm127", W'(r1 < P1), W'(1'b1));
  end

  task automatic applyStimulus(input logic [W-1:0] na, input logic [W-1:0] nb);
    @(negedge clk);
    a = na;
    b = nb;
  endtask

  task automatic waitDrop(output int edges);
    edges = 0;
    while (done0 && edges < 4) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    if (done0) checkOutput("drop_timeout", W'(1'b1), W'(1'b0));
  endtask

  // Counts edges from the latching edge (edge 1) to the edge that raises done.
  task automatic waitRise(output int edges);
    edges = 0;
    while (!done0 && edges < 3*W) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    if (!done0) checkOutput("rise_timeout", W'(1'b0), W'(1'b1));
  endtask

  task automatic runOp(input logic [W-1:0] na, input logic [W-1:0] nb, output int edges);
    int drop;
    applyStimulus(na, nb);
    waitDrop(drop);
    waitRise(edges);
  endtask

  initial begin
    int           edges;
    int           drop;
    logic [W-1:0] na, nb;

    reset = 1'b1;
    a = 123;
    b = 456;
    #1 reset = 1'b0;
    #1;
    checkOutput("reset_r", r0, '0);
    checkOutput("reset_done", W'(done0), '0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    waitRise(edges);
    checkOutput("latency_first", W'(edges), W'(LAT + 1));
    checkOutput("a123_b456", r0, W'(33));
    checkOutput("model_a123_b456", m_r[0], W'(33));
    checkOutput("a123_b456_pm127", r1, W'(56088));

    runOp('0, W'(456), edges);
    checkOutput("a0_b456", r0, '0);
    runOp(W'(1), W'(36), edges);
    checkOutput("a1_b36", r0, W'(36));
    runOp('1, '1, edges);
    checkOutput("allones", r0, W'(25));
    checkOutput("allones_pm127", r1, W'(1));

    runOp(W'(123), W'(456), edges);
    checkOutput("redo_a123_b456", r0, W'(33));
    applyStimulus(W'(123), W'(2));
    waitDrop(drop);
    checkOutput("drop_one_edge", W'(drop), W'(1));
    waitRise(edges);
    checkOutput("latency_change", W'(edges), W'(LAT + 1));
    checkOutput("a123_b2", r0, W'(24));

    applyStimulus(W'(5), W'(7));
    waitDrop(drop);
    repeat (200) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midmul_reset_r", r0, '0);
    checkOutput("midmul_reset_done", W'(done0), '0);
    checkOutput("midmul_reset_r_pm127", r1, '0);
    @(negedge clk);
    reset = 1'b1;
    waitRise(edges);
    checkOutput("latency_after_reset", W'(edges), W'(LAT + 1));
    checkOutput("a5_b7", r0, W'(35));

    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 7))
        0:       begin na = '0;                           nb = rand_word(); end
        1:       begin na = rand_word();                  nb = '0;          end
        2:       begin na = W'($urandom_range(0, 100));   nb = W'($urandom_range(0, 100)); end
        default: begin na = rand_word();                  nb = rand_word(); end
      endcase
      if (na == a && nb == b) na[0] = ~na[0];
      if (i % 8 == 7) begin
        // Operand change mid-computation must not disturb the result in flight.
        applyStimulus(na, nb);
        waitDrop(drop);
        repeat (100) @(negedge clk);
        b = nb ^ W'(1);
        waitRise(edges);
        checkOutput("rand_inflight_r", r0, ref_mod(na, nb, P0));
        waitDrop(drop);
        waitRise(edges);
        nb = b;
      end else begin
        runOp(na, nb, edges);
      end
      checkOutput("rand_latency", W'(edges), W'(LAT + 1));
      checkOutput("rand_r_p37", r0, ref_mod(na, nb, P0));
      checkOutput("rand_r_pm127", r1, ref_mod(na, nb, P1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
